// File: rtl/or1k_branch_predictor_pht_scheduler_pkg.sv
// Shared types and helpers for the PHT scheduler.
// Counter encodings, FSM states, saturating arithmetic.
package or1k_bp_pkg;

   localparam logic [1:0] STRONGLY_NOT_TAKEN = 2'b00;
   localparam logic [1:0] WEAKLY_NOT_TAKEN   = 2'b01;
   localparam logic [1:0] WEAKLY_TAKEN       = 2'b10;
   localparam logic [1:0] STRONGLY_TAKEN     = 2'b11;

   typedef enum logic {INIT, RUN} fsm_e;

   function automatic logic [1:0] sat_inc(
      input logic [1:0] s
   );
      return (s == STRONGLY_TAKEN) ? s : s + 2'd1;
   endfunction

   function automatic logic [1:0] sat_dec(
      input logic [1:0] s
   );
      return (s == STRONGLY_NOT_TAKEN) ? s : s - 2'd1;
   endfunction

endpackage

// File: rtl/or1k_branch_predictor_pht_scheduler_if.sv
// Bundle of lookup, update and PHT RAM signals.
// The slave modport is the scheduler's view.
interface or1k_bp_if #(
   parameter int IDX_W = 6
);
   logic             init_done_o;
   logic             lookup_valid_i;
   logic [IDX_W-1:0] lookup_idx_i;
   logic             lookup_ready_o;
   logic             rsp_valid_o;
   logic [1:0]       rsp_state_o;
   logic             upd_valid_i;
   logic [IDX_W-1:0] upd_idx_i;
   logic [1:0]       upd_state_i;
   logic             upd_taken_i;
   logic             upd_ready_o;
   logic             ram_en_o;
   logic             ram_we_o;
   logic [IDX_W-1:0] ram_addr_o;
   logic [1:0]       ram_wdata_o;
   logic [1:0]       ram_rdata_i;

   modport slave (
      output init_done_o,
      input  lookup_valid_i, lookup_idx_i,
      output lookup_ready_o,
      output rsp_valid_o, rsp_state_o,
      input  upd_valid_i, upd_idx_i,
      input  upd_state_i, upd_taken_i,
      output upd_ready_o,
      output ram_en_o, ram_we_o,
      output ram_addr_o, ram_wdata_o,
      input  ram_rdata_i
   );

   modport master (
      input  init_done_o,
      output lookup_valid_i, lookup_idx_i,
      input  lookup_ready_o,
      input  rsp_valid_o, rsp_state_o,
      output upd_valid_i, upd_idx_i,
      output upd_state_i, upd_taken_i,
      input  upd_ready_o,
      input  ram_en_o, ram_we_o,
      input  ram_addr_o, ram_wdata_o,
      output ram_rdata_i
   );
endinterface

// File: rtl/or1k_branch_predictor_pht_scheduler_fifo.sv
// Update FIFO holding index + already-saturated new state.
// Entries are exposed oldest-first for the forwarding compare.
module or1k_bp_update_fifo #(
   parameter int IDX_W = 6,
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH)
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        push,
   input  logic [IDX_W-1:0]            push_idx,
   input  logic [1:0]                  push_state,
   input  logic                        pop,
   output logic [PW:0]                 count,
   output logic [IDX_W-1:0]            head_idx,
   output logic [1:0]                  head_state,
   output logic [DEPTH-1:0][IDX_W-1:0] ent_idx,
   output logic [DEPTH-1:0][1:0]       ent_state,
   output logic [DEPTH-1:0]            ent_vld
);

   logic [IDX_W-1:0] mem_idx [DEPTH];
   logic [1:0]       mem_st  [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_idx[wr_ptr] <= push_idx;
         mem_st[wr_ptr]  <= push_state;
      end
   end

   assign head_idx   = mem_idx[rd_ptr];
   assign head_state = mem_st[rd_ptr];

   always_comb begin
      for (int k = 0; k < DEPTH; k++) begin
         ent_idx[k]   = mem_idx[rd_ptr + PW'(k)];
         ent_state[k] = mem_st[rd_ptr + PW'(k)];
         ent_vld[k]   = ((PW+1)'(k) < count);
      end
   end

endmodule

// File: rtl/or1k_branch_predictor_pht_scheduler.sv
// Single-port PHT scheduler: init walker, port arbiter,
// update forwarding and one-cycle response register.
module or1k_branch_predictor_pht_scheduler
   import or1k_bp_pkg::*;
#(
   parameter int IDX_W     = 6,
   parameter int UPD_DEPTH = 4,
   localparam int PW = $clog2(UPD_DEPTH)
) (
   input logic clk,
   input logic rst,
   or1k_bp_if.slave bus
);

   fsm_e state;
   fsm_e state_nx;
   logic [IDX_W-1:0] init_cnt;

   logic [PW:0]                     count;
   logic [IDX_W-1:0]                head_idx;
   logic [1:0]                      head_state;
   logic [UPD_DEPTH-1:0][IDX_W-1:0] ent_idx;
   logic [UPD_DEPTH-1:0][1:0]       ent_state;
   logic [UPD_DEPTH-1:0]            ent_vld;

   logic full, empty, push, pop;
   logic [1:0] new_state;
   logic s_init, s_full, s_look, s_drain;
   logic hit, rsp_v, rsp_hit;
   logic [1:0] fwd_val, rsp_fwd;

   assign full  = (count == (PW+1)'(UPD_DEPTH));
   assign empty = (count == '0);

   assign new_state = bus.upd_taken_i ?
                      sat_inc(bus.upd_state_i) :
                      sat_dec(bus.upd_state_i);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= INIT;
      else      state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (state == INIT && init_cnt == '1)
         state_nx = RUN;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                init_cnt <= '0;
      else if (state == INIT)  init_cnt <= init_cnt + 1'b1;
   end

   // Mutually exclusive port owners, in priority order
   assign s_init  = (state == INIT);
   assign s_full  = !s_init && full;
   assign s_look  = !s_init && !full && bus.lookup_valid_i;
   assign s_drain = !s_init && !full &&
                    !bus.lookup_valid_i && !empty;

   always_comb begin
      bus.ram_en_o   = 1'b0;
      bus.ram_we_o   = 1'b0;
      bus.ram_addr_o = '0;
      bus.ram_wdata_o = '0;
      unique case (1'b1)
         s_init: begin
            bus.ram_en_o    = 1'b1;
            bus.ram_we_o    = 1'b1;
            bus.ram_addr_o  = init_cnt;
            bus.ram_wdata_o = WEAKLY_TAKEN;
         end
         s_full, s_drain: begin
            bus.ram_en_o    = 1'b1;
            bus.ram_we_o    = 1'b1;
            bus.ram_addr_o  = head_idx;
            bus.ram_wdata_o = head_state;
         end
         s_look: begin
            bus.ram_en_o   = 1'b1;
            bus.ram_addr_o = bus.lookup_idx_i;
         end
         default: ;
      endcase
   end

   assign bus.init_done_o    = (state == RUN);
   assign bus.lookup_ready_o = s_look;
   assign bus.upd_ready_o    = !s_init && !full;
   assign push = bus.upd_valid_i && bus.upd_ready_o;
   assign pop  = s_full || s_drain;

   or1k_bp_update_fifo #(
      .IDX_W (IDX_W),
      .DEPTH (UPD_DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .push       (push),
      .push_idx   (bus.upd_idx_i),
      .push_state (new_state),
      .pop        (pop),
      .count      (count),
      .head_idx   (head_idx),
      .head_state (head_state),
      .ent_idx    (ent_idx),
      .ent_state  (ent_state),
      .ent_vld    (ent_vld)
   );

   // Later matches are younger, the incoming update youngest
   always_comb begin
      hit     = 1'b0;
      fwd_val = '0;
      for (int k = 0; k < UPD_DEPTH; k++) begin
         if (ent_vld[k] &&
             ent_idx[k] == bus.lookup_idx_i) begin
            hit     = 1'b1;
            fwd_val = ent_state[k];
         end
      end
      if (push && bus.upd_idx_i == bus.lookup_idx_i) begin
         hit     = 1'b1;
         fwd_val = new_state;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rsp_v   <= 1'b0;
         rsp_hit <= 1'b0;
         rsp_fwd <= '0;
      end else begin
         rsp_v   <= s_look;
         rsp_hit <= hit;
         rsp_fwd <= fwd_val;
      end
   end

   assign bus.rsp_valid_o = rsp_v;
   assign bus.rsp_state_o = !rsp_v  ? 2'b00   :
                            rsp_hit ? rsp_fwd :
                            bus.ram_rdata_i;

endmodule
